// File: rtl/kf_host_loader_if.sv
// Stream side of kf_host_loader: the word input stream and the result output stream.
interface kf_host_loader_if #(
    parameter int W = 24
);
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_data;
    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] m_data;
    logic         m_timeout;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready,
        input  m_valid,
        input  m_data,
        input  m_timeout,
        output m_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready,
        output m_valid,
        output m_data,
        output m_timeout,
        input  m_ready
    );
endinterface

// File: rtl/kf_host_loader.sv
// Host-side frame sequencer for kf_top: loads NLOAD words into the data bank, starts a run,
// waits for READY to drop and return (or a timeout), then hands DATA_OUT to the result stream.
module kf_host_loader #(
    parameter int W         = 24,
    parameter int ADDRW     = 5,
    parameter int NLOAD     = 4,
    parameter int BASE_ADDR = 0,
    parameter int TMO_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    kf_host_loader_if.slave   bus,
    input  logic [TMO_W-1:0]  tmo_limit,
    output logic [W-1:0]      kf_data_in,
    output logic [ADDRW-1:0]  kf_dir,
    output logic              kf_write,
    output logic              kf_start,
    input  logic              kf_ready,
    input  logic [W-1:0]      kf_data_out,
    output logic              busy
);
    localparam int CNTW = ADDRW + 1;
    localparam logic [CNTW-1:0]  NLOAD_C = CNTW'(NLOAD);
    localparam logic [CNTW-1:0]  LAST_C  = CNTW'(NLOAD - 1);
    localparam logic [ADDRW-1:0] BASE_C  = ADDRW'(BASE_ADDR);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        OUT
    } state_t;

    state_t           state;
    logic [CNTW-1:0]  count;
    logic [TMO_W-1:0] timer;
    logic             loading;
    logic             accept;
    logic             timed_out;

    // s_ready is also held low while in reset so no word can be handshaken and then lost.
    assign loading     = (state == IDLE) || (state == LOAD);
    assign bus.s_ready = rst_n && loading && kf_ready && (count < NLOAD_C);
    assign accept      = bus.s_valid && bus.s_ready;
    assign timed_out   = (tmo_limit != '0) && (timer == tmo_limit - 1'b1);
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            count         <= '0;
            timer         <= '0;
            kf_data_in    <= '0;
            kf_dir        <= '0;
            kf_write      <= 1'b0;
            kf_start      <= 1'b0;
            bus.m_valid   <= 1'b0;
            bus.m_data    <= '0;
            bus.m_timeout <= 1'b0;
        end else begin
            kf_write <= 1'b0;
            kf_start <= 1'b0;
            case (state)
                IDLE, LOAD: begin
                    if (accept) begin
                        kf_write   <= 1'b1;
                        kf_dir     <= BASE_C + count[ADDRW-1:0];
                        kf_data_in <= bus.s_data;
                        count      <= count + 1'b1;
                        state      <= (count == LAST_C) ? START : LOAD;
                    end
                end
                START: begin
                    kf_start <= 1'b1;
                    timer    <= '0;
                    state    <= WAIT_BUSY;
                end
                // Completion is tested before the timeout so it wins when both land together.
                WAIT_BUSY, WAIT_DONE: begin
                    if (state == WAIT_DONE && kf_ready) begin
                        bus.m_data    <= kf_data_out;
                        bus.m_timeout <= 1'b0;
                        bus.m_valid   <= 1'b1;
                        state         <= OUT;
                    end else if (timed_out) begin
                        bus.m_data    <= '0;
                        bus.m_timeout <= 1'b1;
                        bus.m_valid   <= 1'b1;
                        state         <= OUT;
                    end else if (state == WAIT_BUSY && !kf_ready) begin
                        state <= WAIT_DONE;
                    end
                    if (timer != '1) begin
                        timer <= timer + 1'b1;
                    end
                end
                OUT: begin
                    if (bus.m_ready) begin
                        bus.m_valid <= 1'b0;
                        count       <= '0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_kf_host_loader.sv
// Bench for kf_host_loader: two instances (BASE_ADDR 0 and 30) share all inputs and are
// compared every cycle against a frame-level reference model.
module tb_kf_host_loader;
    localparam int W      = 24;
    localparam int ADDRW  = 5;
    localparam int NLOAD  = 4;
    localparam int TMO_W  = 16;
    localparam int BASE_A = 0;
    localparam int BASE_B = 30;
    localparam int NADDR  = 1 << ADDRW;
    localparam int TMAX   = (1 << TMO_W) - 1;

    localparam int PH_LOAD  = 0;
    localparam int PH_START = 1;
    localparam int PH_RUN   = 2;
    localparam int PH_HOLD  = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [TMO_W-1:0] tmo_limit;
    logic             s_valid;
    logic [W-1:0]     s_data;
    logic             m_ready;
    logic             kf_ready;
    logic [W-1:0]     kf_data_out;

    logic [W-1:0]     kf_data_in_a, kf_data_in_b;
    logic [ADDRW-1:0] kf_dir_a, kf_dir_b;
    logic             kf_write_a, kf_write_b;
    logic             kf_start_a, kf_start_b;
    logic             busy_a, busy_b;

    kf_host_loader_if #(.W(W)) bus_a ();
    kf_host_loader_if #(.W(W)) bus_b ();

    assign bus_a.s_valid = s_valid;
    assign bus_a.s_data  = s_data;
    assign bus_a.m_ready = m_ready;
    assign bus_b.s_valid = s_valid;
    assign bus_b.s_data  = s_data;
    assign bus_b.m_ready = m_ready;

    kf_host_loader #(.W(W), .ADDRW(ADDRW), .NLOAD(NLOAD), .BASE_ADDR(BASE_A), .TMO_W(TMO_W)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a.slave), .tmo_limit(tmo_limit),
        .kf_data_in(kf_data_in_a), .kf_dir(kf_dir_a), .kf_write(kf_write_a), .kf_start(kf_start_a),
        .kf_ready(kf_ready), .kf_data_out(kf_data_out), .busy(busy_a)
    );

    kf_host_loader #(.W(W), .ADDRW(ADDRW), .NLOAD(NLOAD), .BASE_ADDR(BASE_B), .TMO_W(TMO_W)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b.slave), .tmo_limit(tmo_limit),
        .kf_data_in(kf_data_in_b), .kf_dir(kf_dir_b), .kf_write(kf_write_b), .kf_start(kf_start_b),
        .kf_ready(kf_ready), .kf_data_out(kf_data_out), .busy(busy_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: frame phase, words taken, cycles spent waiting, and expected outputs.
    int           ph;
    int           loaded;
    int           elapsed;
    bit           seen_low;
    bit           e_write, e_start, e_mvalid, e_mto;
    int           e_dir_a, e_dir_b;
    logic [W-1:0] e_din, e_mdata;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic check_all();
        logic e_busy;
        e_busy = !(ph == PH_LOAD && loaded == 0);
        check_output("kf_write_a",   32'(kf_write_a),      32'(e_write));
        check_output("kf_write_b",   32'(kf_write_b),      32'(e_write));
        check_output("kf_start_a",   32'(kf_start_a),      32'(e_start));
        check_output("kf_start_b",   32'(kf_start_b),      32'(e_start));
        check_output("kf_dir_a",     32'(kf_dir_a),        32'(e_dir_a));
        check_output("kf_dir_b",     32'(kf_dir_b),        32'(e_dir_b));
        check_output("kf_data_in_a", 32'(kf_data_in_a),    32'(e_din));
        check_output("kf_data_in_b", 32'(kf_data_in_b),    32'(e_din));
        check_output("m_valid_a",    32'(bus_a.m_valid),   32'(e_mvalid));
        check_output("m_valid_b",    32'(bus_b.m_valid),   32'(e_mvalid));
        check_output("m_data_a",     32'(bus_a.m_data),    32'(e_mdata));
        check_output("m_data_b",     32'(bus_b.m_data),    32'(e_mdata));
        check_output("m_timeout_a",  32'(bus_a.m_timeout), 32'(e_mto));
        check_output("m_timeout_b",  32'(bus_b.m_timeout), 32'(e_mto));
        check_output("busy_a",       32'(busy_a),          32'(e_busy));
        check_output("busy_b",       32'(busy_b),          32'(e_busy));
    endtask

    task automatic model_reset();
        ph       = PH_LOAD;
        loaded   = 0;
        elapsed  = 0;
        seen_low = 1'b0;
        e_write  = 1'b0;
        e_start  = 1'b0;
        e_mvalid = 1'b0;
        e_mto    = 1'b0;
        e_dir_a  = 0;
        e_dir_b  = 0;
        e_din    = '0;
        e_mdata  = '0;
    endtask

    // One clock cycle: drive inputs, check s_ready, advance the model, check registered outputs.
    task automatic apply_stimulus(input bit sv, input logic [W-1:0] sd, input bit kr,
                                  input logic [W-1:0] kdo, input bit mr);
        bit exp_sready, accept, done, tmo;
        s_valid     = sv;
        s_data      = sd;
        kf_ready    = kr;
        kf_data_out = kdo;
        m_ready     = mr;
        #1;
        exp_sready = (ph == PH_LOAD) && kr && (loaded < NLOAD);
        check_output("s_ready_a", 32'(bus_a.s_ready), 32'(exp_sready));
        check_output("s_ready_b", 32'(bus_b.s_ready), 32'(exp_sready));
        accept  = sv && exp_sready;
        e_write = accept;
        e_start = (ph == PH_START);
        case (ph)
            PH_LOAD: begin
                if (accept) begin
                    e_din   = sd;
                    e_dir_a = (BASE_A + loaded) % NADDR;
                    e_dir_b = (BASE_B + loaded) % NADDR;
                    loaded++;
                    if (loaded == NLOAD) ph = PH_START;
                end
            end
            PH_START: begin
                ph       = PH_RUN;
                elapsed  = 0;
                seen_low = 1'b0;
            end
            PH_RUN: begin
                done = seen_low && kr;
                tmo  = (tmo_limit != '0) && (elapsed == int'(tmo_limit) - 1);
                if (done) begin
                    e_mvalid = 1'b1;
                    e_mdata  = kdo;
                    e_mto    = 1'b0;
                    ph       = PH_HOLD;
                end else if (tmo) begin
                    e_mvalid = 1'b1;
                    e_mdata  = '0;
                    e_mto    = 1'b1;
                    ph       = PH_HOLD;
                end else begin
                    if (!kr) seen_low = 1'b1;
                    if (elapsed < TMAX) elapsed++;
                end
            end
            default: begin
                if (mr) begin
                    e_mvalid = 1'b0;
                    ph       = PH_LOAD;
                    loaded   = 0;
                end
            end
        endcase
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset(input int cycles);
        rst_n    = 1'b0;
        s_valid  = 1'b0;
        m_ready  = 1'b0;
        kf_ready = 1'b1;
        model_reset();
        #1;
        check_output("reset_s_ready_a", 32'(bus_a.s_ready), 32'd0);
        check_all();
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            check_all();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired before the bench completed");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lat;
        rst_n       = 1'b0;
        tmo_limit   = '0;
        s_valid     = 1'b0;
        s_data      = '0;
        m_ready     = 1'b0;
        kf_ready    = 1'b1;
        kf_data_out = '0;
        do_reset(3);

        $display("[TB] back-to-back frame load and a long run");
        for (int k = 0; k < NLOAD; k++) apply_stimulus(1'b1, W'((k + 1) * 'h100), 1'b1, '0, 1'b0);
        apply_stimulus(1'b0, '0, 1'b1, '0, 1'b0);
        apply_stimulus(1'b0, '0, 1'b1, '0, 1'b0);
        for (int i = 0; i < 30; i++) apply_stimulus(1'b0, '0, 1'b0, W'($urandom), 1'b0);
        apply_stimulus(1'b0, '0, 1'b1, 24'h123456, 1'b0);
        check_output("t2_m_data", 32'(bus_a.m_data), 32'h123456);
        for (int i = 0; i < 5; i++) apply_stimulus(1'b1, W'($urandom), 1'b1, W'($urandom), 1'b0);
        check_output("t2_hold_m_data", 32'(bus_a.m_data), 32'h123456);
        apply_stimulus(1'b0, '0, 1'b1, '0, 1'b1);

        $display("[TB] timeout with READY stuck low");
        tmo_limit = 16'd10;
        for (int k = 0; k < NLOAD; k++) apply_stimulus(1'b1, W'($urandom), 1'b1, '0, 1'b0);
        apply_stimulus(1'b0, '0, 1'b1, '0, 1'b0);
        lat = 0;
        while (bus_a.m_valid !== 1'b1 && lat < 40) begin
            apply_stimulus(1'b0, '0, 1'b0, W'($urandom), 1'b0);
            lat++;
        end
        check_output("t3_timeout_latency", 32'(lat), 32'd10);
        check_output("t3_m_timeout", 32'(bus_a.m_timeout), 32'd1);
        apply_stimulus(1'b0, '0, 1'b0, '0, 1'b1);

        $display("[TB] toggling s_valid with address wrap");
        tmo_limit = '0;
        for (int i = 0; i < 8; i++) apply_stimulus(i % 2 == 0, W'($urandom), 1'b1, '0, 1'b0);
        apply_stimulus(1'b0, '0, 1'b1, '0, 1'b0);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, '0, 1'b0, '0, 1'b0);
        apply_stimulus(1'b0, '0, 1'b1, W'($urandom), 1'b1);
        apply_stimulus(1'b0, '0, 1'b1, '0, 1'b1);

        $display("[TB] reset in the middle of a frame");
        for (int k = 0; k < 2; k++) apply_stimulus(1'b1, W'($urandom), 1'b1, '0, 1'b0);
        do_reset(2);
        apply_stimulus(1'b1, 24'hABCDEF, 1'b1, '0, 1'b0);
        check_output("t5_restart_dir_a", 32'(kf_dir_a), 32'd0);
        check_output("t5_restart_dir_b", 32'(kf_dir_b), 32'd30);
        for (int k = 1; k < NLOAD; k++) apply_stimulus(1'b1, W'($urandom), 1'b1, '0, 1'b0);
        apply_stimulus(1'b0, '0, 1'b1, '0, 1'b0);
        apply_stimulus(1'b0, '0, 1'b0, '0, 1'b0);
        apply_stimulus(1'b0, '0, 1'b1, W'($urandom), 1'b1);
        apply_stimulus(1'b0, '0, 1'b1, '0, 1'b0);

        $display("[TB] READY low before any accept");
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, W'($urandom), 1'b0, '0, 1'b0);
        for (int k = 0; k < NLOAD; k++) apply_stimulus(1'b1, W'($urandom), 1'b1, '0, 1'b0);
        apply_stimulus(1'b0, '0, 1'b1, '0, 1'b0);
        apply_stimulus(1'b0, '0, 1'b0, '0, 1'b0);
        apply_stimulus(1'b0, '0, 1'b1, W'($urandom), 1'b1);

        $display("[TB] randomized frames");
        for (int f = 0; f < 20; f++) begin
            int pre_hi, lo_len, since_start, cyc;
            bit started, sv, kr, mr;
            tmo_limit   = ($urandom_range(0, 2) == 0) ? '0 : TMO_W'($urandom_range(6, 40));
            pre_hi      = $urandom_range(0, 3);
            lo_len      = $urandom_range(1, 40);
            since_start = 0;
            started     = 1'b0;
            cyc         = 0;
            while (!(started && ph == PH_LOAD && loaded == 0) && cyc < 400) begin
                sv = ($urandom_range(0, 2) != 0);
                mr = ($urandom_range(0, 2) == 0);
                if (ph == PH_LOAD) begin
                    kr = ($urandom_range(0, 5) != 0);
                end else begin
                    kr = !(since_start >= pre_hi && since_start < pre_hi + lo_len);
                    since_start++;
                end
                apply_stimulus(sv, W'($urandom), kr, W'($urandom), mr);
                if (ph != PH_LOAD || loaded != 0) started = 1'b1;
                cyc++;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
